// File: rtl/led_bar_ctrl.sv
// Clocked LED bar/dot level display with change-flash and exhausted-bar alarm blink.
// Define LED_ACTIVE_LOW_EN to drive led inverted (0 = lit) for active-low boards.
module led_bar_ctrl #(
   parameter int N_LED         = 6,
   parameter int LEN_W         = 3,
   parameter int BLINK_DIV     = 12500000,
   parameter int FLASH_TOGGLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [LEN_W-1:0] level,
   input  logic             mode,
   output logic [N_LED-1:0] led,
   output logic             flashing,
   output logic             alarm
);

   localparam int NW = $clog2(N_LED + 1);
   localparam int CW = (LEN_W > NW) ? LEN_W : NW;
   localparam int PW = $clog2(BLINK_DIV);
   localparam int TW = $clog2(FLASH_TOGGLES);
   localparam logic [CW-1:0]    N_EXT    = CW'(N_LED);
   localparam logic [PW-1:0]    PRE_MAX  = PW'(BLINK_DIV - 1);
   localparam logic [TW-1:0]    TOG_LAST = TW'(FLASH_TOGGLES - 1);
   localparam logic [N_LED-1:0] ALL_ON   = '1;

   typedef enum logic [1:0] {STEADY, FLASH, ALARM} state_t;

   state_t           state;
   logic [LEN_W-1:0] level_q;
   logic [PW-1:0]    pre;
   logic [TW-1:0]    tog;
   logic             phase;

   logic [CW-1:0]    level_ext;
   logic [CW-1:0]    lit;
   logic             over;
   logic             tick;
   logic             changed;
   logic [N_LED-1:0] pattern;

   // Lit-pattern to pin polarity; everything upstream works in "1 = lit".
   function automatic logic [N_LED-1:0] drv(input logic [N_LED-1:0] on);
`ifdef LED_ACTIVE_LOW_EN
      return ~on;
`else
      return on;
`endif
   endfunction

   always_comb begin
      level_ext = CW'(level);
      over      = (level_ext >= N_EXT);
      lit       = over ? '0 : (N_EXT - level_ext);
      tick      = (pre == PRE_MAX);
      changed   = (level != level_q);
      pattern   = '0;
      for (int i = 0; i < N_LED; i++) begin
         if (mode) pattern[i] = ((i + 1) == int'(lit));
         else      pattern[i] = (i < int'(lit));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= STEADY;
         level_q  <= '0;
         pre      <= '0;
         tog      <= '0;
         phase    <= 1'b1;
         led      <= drv('0);
         flashing <= 1'b0;
         alarm    <= 1'b0;
      end else begin
         level_q <= level;
         if (over) begin
            if (state != ALARM) begin
               state    <= ALARM;
               pre      <= '0;
               tog      <= '0;
               phase    <= 1'b0;
               led      <= drv('0);
               flashing <= 1'b0;
               alarm    <= 1'b1;
            end else begin
               // Level moves that stay exhausted keep the blink cadence intact.
               pre <= tick ? '0 : pre + 1'b1;
               if (tick) phase <= ~phase;
               led <= drv((tick ? ~phase : phase) ? ALL_ON : '0);
            end
         end else if (state == ALARM || changed) begin
            state    <= FLASH;
            pre      <= '0;
            tog      <= '0;
            phase    <= 1'b0;
            led      <= drv('0);
            flashing <= 1'b1;
            alarm    <= 1'b0;
         end else if (state == FLASH) begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick && tog == TOG_LAST) begin
               state    <= STEADY;
               tog      <= '0;
               phase    <= 1'b1;
               led      <= drv(pattern);
               flashing <= 1'b0;
            end else if (tick) begin
               tog   <= tog + 1'b1;
               phase <= ~phase;
               led   <= drv(phase ? '0 : pattern);
            end else begin
               led <= drv(phase ? pattern : '0);
            end
         end else begin
            pre <= tick ? '0 : pre + 1'b1;
            led <= drv(pattern);
         end
      end
   end

endmodule

// File: tb/tb_led_bar_ctrl.sv
// Bench for led_bar_ctrl (N_LED=6, LEN_W=3, BLINK_DIV=4, FLASH_TOGGLES=4); per-cycle vector table
// with hand-derived expectations, plus async-reset corner sequences. Honors LED_ACTIVE_LOW_EN.
module tb_led_bar_ctrl;
   localparam int N_LED = 6;
   localparam int LEN_W = 3;
   localparam int W     = N_LED + 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [LEN_W-1:0] level;
   logic             mode;
   logic [N_LED-1:0] led;
   logic             flashing;
   logic             alarm;

   led_bar_ctrl #(
      .N_LED(N_LED), .LEN_W(LEN_W), .BLINK_DIV(4), .FLASH_TOGGLES(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .level(level), .mode(mode),
      .led(led), .flashing(flashing), .alarm(alarm)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [LEN_W-1:0] lvl;
      logic             md;
      int               n;
      logic [N_LED-1:0] led;
      logic             fl;
      logic             al;
   } vec_t;

   vec_t       vecs[$];
   logic [W-1:0] exp_q[$];
   int         n_vec = 0;
   int         n_bad = 0;

   function automatic logic [N_LED-1:0] drv(input logic [N_LED-1:0] on);
`ifdef LED_ACTIVE_LOW_EN
      return ~on;
`else
      return on;
`endif
   endfunction

   function automatic void add(input logic [LEN_W-1:0] l, input logic m, input int n,
                               input logic [N_LED-1:0] e, input logic f, input logic a);
      vecs.push_back('{l, m, n, e, f, a});
   endfunction

   task automatic expect_out(input logic [N_LED-1:0] e, input logic f, input logic a);
      exp_q.push_back({drv(e), f, a});
   endtask

   task automatic compare_out(input string name);
      logic [W-1:0] exp;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL %s: no expected entry queued, got led=%b fl=%b al=%b", name, led, flashing, alarm);
      end else begin
         exp = exp_q.pop_front();
         if ({led, flashing, alarm} !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got led=%b fl=%b al=%b, want led=%b fl=%b al=%b",
                     name, $time, led, flashing, alarm, exp[W-1:2], exp[1], exp[0]);
         end
      end
   endtask

   task automatic run_table(input string name);
      foreach (vecs[k]) begin
         for (int c = 0; c < vecs[k].n; c++) begin
            @(negedge clk);
            level = vecs[k].lvl;
            mode  = vecs[k].md;
            expect_out(vecs[k].led, vecs[k].fl, vecs[k].al);
            @(posedge clk);
            #1;
            compare_out($sformatf("%s[%0d].%0d", name, k, c));
         end
      end
      vecs.delete();
   endtask

   initial begin
      rst_n = 1'b0;
      level = '0;
      mode  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      expect_out('0, 1'b0, 1'b0);
      compare_out("in_reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Steady start, then 0->2 flash
      add(3'd0, 0, 3, 6'b111111, 0, 0);
      add(3'd2, 0, 4, 6'b000000, 1, 0);
      add(3'd2, 0, 4, 6'b001111, 1, 0);
      add(3'd2, 0, 4, 6'b000000, 1, 0);
      add(3'd2, 0, 4, 6'b001111, 1, 0);
      add(3'd2, 0, 3, 6'b001111, 0, 0);
      // 2->1 flash, restarted at cycle 6 by 1->3
      add(3'd1, 0, 4, 6'b000000, 1, 0);
      add(3'd1, 0, 2, 6'b011111, 1, 0);
      add(3'd3, 0, 4, 6'b000000, 1, 0);
      add(3'd3, 0, 4, 6'b000111, 1, 0);
      add(3'd3, 0, 4, 6'b000000, 1, 0);
      add(3'd3, 0, 4, 6'b000111, 1, 0);
      add(3'd3, 0, 3, 6'b000111, 0, 0);
      // Alarm at 6, mid-phase move to 7 keeps cadence, release to 5
      add(3'd6, 0, 4, 6'b000000, 0, 1);
      add(3'd6, 0, 2, 6'b111111, 0, 1);
      add(3'd7, 0, 2, 6'b111111, 0, 1);
      add(3'd7, 0, 4, 6'b000000, 0, 1);
      add(3'd7, 0, 4, 6'b111111, 0, 1);
      add(3'd5, 0, 4, 6'b000000, 1, 0);
      add(3'd5, 0, 4, 6'b000001, 1, 0);
      add(3'd5, 0, 4, 6'b000000, 1, 0);
      add(3'd5, 0, 4, 6'b000001, 1, 0);
      add(3'd5, 0, 3, 6'b000001, 0, 0);
      // Level 1 flash, then dot mode and back: no flash from mode
      add(3'd1, 0, 4, 6'b000000, 1, 0);
      add(3'd1, 0, 4, 6'b011111, 1, 0);
      add(3'd1, 0, 4, 6'b000000, 1, 0);
      add(3'd1, 0, 4, 6'b011111, 1, 0);
      add(3'd1, 0, 2, 6'b011111, 0, 0);
      add(3'd1, 1, 3, 6'b010000, 0, 0);
      add(3'd1, 0, 2, 6'b011111, 0, 0);
      // Dot at the lowest lit LED, then straight into alarm
      add(3'd5, 1, 4, 6'b000000, 1, 0);
      add(3'd5, 1, 4, 6'b000001, 1, 0);
      add(3'd7, 1, 4, 6'b000000, 0, 1);
      add(3'd7, 1, 2, 6'b111111, 0, 1);
      run_table("table");

      // Asynchronous reset mid-alarm: outputs must clear before any clock edge
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      level = '0;
      mode  = 1'b0;
      #1;
      expect_out('0, 1'b0, 1'b0);
      compare_out("async_reset");
      @(posedge clk);
      #1;
      expect_out('0, 1'b0, 1'b0);
      compare_out("reset_hold");
      @(negedge clk);
      rst_n = 1'b1;
      add(3'd0, 0, 3, 6'b111111, 0, 0);
      run_table("post_reset");

      // Reset during a flash also lands in steady without flashing
      add(3'd4, 0, 3, 6'b000000, 1, 0);
      run_table("pre_flash");
      @(negedge clk);
      rst_n = 1'b0;
      level = 3'd4;
      #1;
      expect_out('0, 1'b0, 1'b0);
      compare_out("reset_mid_flash");
      @(negedge clk);
      rst_n = 1'b1;
      level = 3'd0;
      add(3'd0, 0, 2, 6'b111111, 0, 0);
      run_table("after_flash_reset");

      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL leftover: got %0d queued entries, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got time %0t", $time);
      $fatal(1);
   end

endmodule
